// File: rtl/uart_rcv_fifo.sv
// UART receiver with mid-bit sampling, optional parity, sticky error flags and
// a show-ahead FIFO so frames arriving while the consumer is busy are kept.
module uart_rcv_fifo #(
  parameter int CLK_DIV    = 2604,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          RX,
  input  logic                          rd_en,
  input  logic                          clr_err,
  output logic [DATA_BITS-1:0]          rx_data,
  output logic                          rdy,
  output logic [$clog2(FIFO_DEPTH):0]   count,
  output logic                          parity_err,
  output logic                          frame_err,
  output logic                          overrun
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int BW = $clog2(CLK_DIV);

  localparam logic [BW-1:0] HALF_M1  = BW'(CLK_DIV / 2 - 1);
  localparam logic [BW-1:0] DIV_M1   = BW'(CLK_DIV - 1);
  localparam logic [3:0]    LAST_BIT = 4'(DATA_BITS - 1);
  localparam logic [AW:0]   DEPTH_C  = (AW + 1)'(FIFO_DEPTH);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_START   = 3'd1;
  localparam logic [2:0] S_DATA    = 3'd2;
  localparam logic [2:0] S_PAR     = 3'd3;
  localparam logic [2:0] S_STOP    = 3'd4;
  localparam logic [2:0] S_WAIT_HI = 3'd5;

  // Running XOR covers data and parity bits; odd parity expects it to end at 1.
  function automatic logic parity_bad(input logic acc);
    if (PARITY == 1)      return acc;
    else if (PARITY == 2) return ~acc;
    else                  return 1'b0;
  endfunction

  logic                 rx_meta_q, rx_s_q;
  logic [2:0]           state_q, state_d;
  logic [BW-1:0]        baud_q, baud_d;
  logic [3:0]           bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_q, par_d;

  logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr_q, rd_ptr_q;
  logic [AW:0]          count_q;

  logic                 perr_q, ferr_q, ovr_q;

  logic tick, pop, push, set_fe, set_pe, set_ov, full_after_pop;

  assign tick           = (baud_q == '0);
  assign pop            = rd_en && (count_q != '0);
  assign full_after_pop = (count_q == DEPTH_C) && !pop;

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      rx_meta_q <= RX;
      rx_s_q    <= rx_meta_q;
    end
  end

  always_comb begin
    state_d = state_q;
    baud_d  = tick ? DIV_M1 : baud_q - 1'b1;
    bit_d   = bit_q;
    shift_d = shift_q;
    par_d   = par_q;
    push    = 1'b0;
    set_fe  = 1'b0;
    set_pe  = 1'b0;
    set_ov  = 1'b0;
    case (state_q)
      S_IDLE: begin
        baud_d = HALF_M1;
        bit_d  = '0;
        par_d  = 1'b0;
        if (!rx_s_q) state_d = S_START;
      end
      S_START: begin
        if (tick) state_d = rx_s_q ? S_IDLE : S_DATA;
      end
      S_DATA: begin
        if (tick) begin
          shift_d = {rx_s_q, shift_q[DATA_BITS-1:1]};
          par_d   = par_q ^ rx_s_q;
          bit_d   = bit_q + 4'd1;
          if (bit_q == LAST_BIT) state_d = (PARITY != 0) ? S_PAR : S_STOP;
        end
      end
      S_PAR: begin
        if (tick) begin
          par_d   = par_q ^ rx_s_q;
          state_d = S_STOP;
        end
      end
      S_STOP: begin
        if (tick) begin
          if (!rx_s_q) begin
            set_fe  = 1'b1;
            state_d = S_WAIT_HI;
          end else if (parity_bad(par_q)) begin
            set_pe  = 1'b1;
            state_d = S_IDLE;
          end else begin
            if (full_after_pop) set_ov = 1'b1;
            else                push   = 1'b1;
            state_d = S_IDLE;
          end
        end
      end
      S_WAIT_HI: begin
        // A held-low line (break) must not look like a stream of start bits.
        if (rx_s_q) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      baud_q  <= HALF_M1;
      bit_q   <= '0;
      par_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      par_q   <= par_d;
    end
  end

  always_ff @(posedge clk) begin
    shift_q <= shift_d;
    if (push) mem_q[wr_ptr_q] <= shift_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // A new error event in the same cycle as clr_err keeps the flag set.
  always_ff @(posedge clk) begin
    if (rst) begin
      perr_q <= 1'b0;
      ferr_q <= 1'b0;
      ovr_q  <= 1'b0;
    end else begin
      perr_q <= set_pe | (perr_q & ~clr_err);
      ferr_q <= set_fe | (ferr_q & ~clr_err);
      ovr_q  <= set_ov | (ovr_q & ~clr_err);
    end
  end

  assign rdy        = (count_q != '0);
  assign count      = count_q;
  assign rx_data    = rdy ? mem_q[rd_ptr_q] : '0;
  assign parity_err = perr_q;
  assign frame_err  = ferr_q;
  assign overrun    = ovr_q;

endmodule

// File: tb/tb_uart_rcv_fifo.sv
// Directed bench: an 8N1 receiver (A) and a 7E1 receiver (B), both 16 clocks/bit.
module tb_uart_rcv_fifo;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx_a = 1'b1, rx_b = 1'b1;
  logic       rd_en_a = 1'b0, clr_a = 1'b0;
  logic       rd_en_b = 1'b0, clr_b = 1'b0;
  logic [7:0] data_a;
  logic [6:0] data_b;
  logic [2:0] count_a, count_b;
  logic       rdy_a, rdy_b, pe_a, pe_b, fe_a, fe_b, ov_a, ov_b;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int start_cyc;
  logic arm = 1'b0;
  logic rise_seen = 1'b0;
  int   rise_cyc = 0;

  always #5 clk = ~clk;

  uart_rcv_fifo #(.CLK_DIV(16), .DATA_BITS(8), .PARITY(0), .FIFO_DEPTH(4)) dut_a (
    .clk(clk), .rst(rst), .RX(rx_a), .rd_en(rd_en_a), .clr_err(clr_a),
    .rx_data(data_a), .rdy(rdy_a), .count(count_a),
    .parity_err(pe_a), .frame_err(fe_a), .overrun(ov_a)
  );

  uart_rcv_fifo #(.CLK_DIV(16), .DATA_BITS(7), .PARITY(1), .FIFO_DEPTH(4)) dut_b (
    .clk(clk), .rst(rst), .RX(rx_b), .rd_en(rd_en_b), .clr_err(clr_b),
    .rx_data(data_b), .rdy(rdy_b), .count(count_b),
    .parity_err(pe_b), .frame_err(fe_b), .overrun(ov_b)
  );

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (arm && !rise_seen && rdy_a) begin
      rise_seen <= 1'b1;
      rise_cyc  <= cyc;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // par < 0 means no parity bit; pop_cyc/clr_cyc pulse rd_en/clr_err of A in that bit-clock.
  task automatic send_frame(input int sel, input logic [8:0] data, input int dbits,
                            input int par, input logic stop, input int pop_cyc,
                            input int clr_cyc);
    logic [11:0] fr;
    int n;
    fr    = '1;
    fr[0] = 1'b0;
    for (int i = 0; i < dbits; i++) fr[1+i] = data[i];
    n = 1 + dbits;
    if (par >= 0) begin
      fr[n] = par[0];
      n++;
    end
    fr[n] = stop;
    n++;
    for (int c = 0; c < n * 16; c++) begin
      if (sel == 0) rx_a = fr[c/16];
      else          rx_b = fr[c/16];
      rd_en_a = (c == pop_cyc);
      clr_a   = (c == clr_cyc);
      @(negedge clk);
    end
    rd_en_a = 1'b0;
    clr_a   = 1'b0;
  endtask

  task automatic send_a(input logic [7:0] d);
    send_frame(0, {1'b0, d}, 8, -1, 1'b1, -1, -1);
  endtask

  task automatic pop_a();
    rd_en_a = 1'b1;
    @(negedge clk);
    rd_en_a = 1'b0;
  endtask

  task automatic pulse_clr_a();
    clr_a = 1'b1;
    @(negedge clk);
    clr_a = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1);
  end

  initial begin
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check_eq("rst_rdy", rdy_a, 0);
    check_eq("rst_count", count_a, 0);
    check_eq("rst_perr", pe_a, 0);
    check_eq("rst_ferr", fe_a, 0);
    check_eq("rst_ovr", ov_a, 0);
    check_eq("rst_data", data_a, 0);
    repeat (5) @(negedge clk);

    start_cyc = cyc;
    arm = 1'b1;
    send_a(8'hA5);
    repeat (2) @(negedge clk);
    arm = 1'b0;
    check_eq("a5_latency", rise_cyc - start_cyc, 155);
    check_eq("a5_data", data_a, 8'hA5);
    pop_a();
    check_eq("a5_empty", rdy_a, 0);

    for (int i = 1; i <= 5; i++) send_a(8'(i));
    repeat (4) @(negedge clk);
    check_eq("b2b_count", count_a, 4);
    check_eq("b2b_ovr", ov_a, 1);
    for (int i = 1; i <= 4; i++) begin
      check_eq("b2b_head", data_a, i);
      pop_a();
    end
    check_eq("b2b_drained", rdy_a, 0);
    pulse_clr_a();
    check_eq("ovr_cleared", ov_a, 0);

    send_frame(0, 9'h03C, 8, -1, 1'b0, -1, -1);
    repeat (480) @(negedge clk);
    check_eq("brk_ferr", fe_a, 1);
    check_eq("brk_count", count_a, 0);
    check_eq("brk_ovr", ov_a, 0);
    check_eq("brk_perr", pe_a, 0);
    rx_a = 1'b1;
    repeat (20) @(negedge clk);
    pulse_clr_a();
    check_eq("ferr_cleared", fe_a, 0);
    send_a(8'h3C);
    repeat (4) @(negedge clk);
    check_eq("after_brk_count", count_a, 1);
    check_eq("after_brk_data", data_a, 8'h3C);
    pop_a();

    rx_a = 1'b0;
    repeat (4) @(negedge clk);
    rx_a = 1'b1;
    repeat (200) @(negedge clk);
    check_eq("fstart_count", count_a, 0);
    check_eq("fstart_ferr", fe_a, 0);
    check_eq("fstart_ovr", ov_a, 0);

    send_a(8'h11);
    send_a(8'h22);
    send_a(8'h33);
    send_a(8'h44);
    send_frame(0, 9'h077, 8, -1, 1'b1, 154, -1);
    repeat (4) @(negedge clk);
    check_eq("simul_ovr", ov_a, 0);
    check_eq("simul_count", count_a, 4);
    check_eq("simul_h0", data_a, 8'h22); pop_a();
    check_eq("simul_h1", data_a, 8'h33); pop_a();
    check_eq("simul_h2", data_a, 8'h44); pop_a();
    check_eq("simul_h3", data_a, 8'h77); pop_a();
    check_eq("simul_empty", rdy_a, 0);

    send_frame(0, 9'h03C, 8, -1, 1'b0, -1, 154);
    rx_a = 1'b1;
    repeat (20) @(negedge clk);
    check_eq("clr_vs_set_ferr", fe_a, 1);
    pulse_clr_a();
    check_eq("clr_only_ferr", fe_a, 0);

    send_a(8'h66);
    send_frame(0, 9'h0C3, 8, -1, 1'b0, -1, -1);
    rx_a = 1'b1;
    repeat (20) @(negedge clk);
    check_eq("pre_rst_count", count_a, 1);
    check_eq("pre_rst_ferr", fe_a, 1);
    rx_a = 1'b0;
    repeat (40) @(negedge clk);
    rst  = 1'b1;
    rx_a = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_eq("mid_rst_count", count_a, 0);
    check_eq("mid_rst_rdy", rdy_a, 0);
    check_eq("mid_rst_data", data_a, 0);
    check_eq("mid_rst_ferr", fe_a, 0);
    repeat (10) @(negedge clk);
    send_a(8'h5A);
    repeat (4) @(negedge clk);
    check_eq("post_rst_count", count_a, 1);
    check_eq("post_rst_data", data_a, 8'h5A);

    send_frame(1, 9'h035, 7, 0, 1'b1, -1, -1);
    repeat (4) @(negedge clk);
    check_eq("par_ok_count", count_b, 1);
    check_eq("par_ok_data", data_b, 7'h35);
    check_eq("par_ok_perr", pe_b, 0);
    send_frame(1, 9'h035, 7, 1, 1'b1, -1, -1);
    repeat (4) @(negedge clk);
    check_eq("par_bad_perr", pe_b, 1);
    check_eq("par_bad_count", count_b, 1);
    check_eq("par_bad_ferr", fe_b, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
